// File: rtl/lcd_msg_streamer_if.sv
// Host-side control/message bus and LCD pin group for lcd_msg_streamer.
interface lcd_msg_streamer_if #(
  parameter int unsigned MSG_LEN = 16
);
  localparam int unsigned ADDR_W = $clog2(MSG_LEN);

  logic              start;
  logic              msg_wr_en;
  logic [ADDR_W-1:0] msg_wr_addr;
  logic [7:0]        msg_wr_data;
  logic              busy;
  logic              done;
  logic [7:0]        lcd_data;
  logic              lcd_rs;
  logic              lcd_rw;
  logic              lcd_en;

  // Host / controller side
  modport master (
    output start, msg_wr_en, msg_wr_addr, msg_wr_data,
    input  busy, done, lcd_data, lcd_rs, lcd_rw, lcd_en
  );

  // Streamer side
  modport slave (
    input  start, msg_wr_en, msg_wr_addr, msg_wr_data,
    output busy, done, lcd_data, lcd_rs, lcd_rw, lcd_en
  );
endinterface

// File: rtl/lcd_msg_streamer.sv
// HD44780-style character LCD streamer: 4 init commands, then MSG_LEN message bytes,
// each framed by programmable setup / enable-pulse / settle timing.
module lcd_msg_streamer #(
  parameter int unsigned MSG_LEN        = 16,
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned EN_PULSE_CYC   = 4,
  parameter int unsigned GAP_CYC        = 40,
  parameter int unsigned CLEAR_WAIT_CYC = 1600
) (
  input logic               clk,
  input logic               reset,
  lcd_msg_streamer_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(MSG_LEN);
  localparam int unsigned IDX_W  = $clog2(MSG_LEN + 4);
  localparam int unsigned TMR_W  = $clog2(CLEAR_WAIT_CYC + 1);

  localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(MSG_LEN + 3);
  localparam logic [TMR_W-1:0] SetupLoad = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PulseLoad = TMR_W'(EN_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GapLoad   = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] ClearLoad = TMR_W'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StGap, StFin} state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic              rs_q, rs_d;
  logic [7:0]        mem_q [MSG_LEN];

  logic              busy;
  logic              wr_ok;
  logic [IDX_W-1:0]  next_idx;
  logic [ADDR_W-1:0] msg_sel;
  logic [7:0]        next_byte;
  logic              timer_zero;
  logic              clear_cmd;

  assign busy       = (state_q == StSetup) || (state_q == StPulse) || (state_q == StGap);
  assign timer_zero = (timer_q == '0);
  assign clear_cmd  = !rs_q && (data_q == 8'h01);
  assign next_idx   = idx_q + 1'b1;
  assign msg_sel    = ADDR_W'(next_idx - IDX_W'(4));
  assign wr_ok      = bus.msg_wr_en && !busy &&
                      ({1'b0, bus.msg_wr_addr} < (ADDR_W + 1)'(MSG_LEN));

  assign bus.busy     = busy;
  assign bus.done     = (state_q == StFin);
  assign bus.lcd_en   = (state_q == StPulse);
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_data = data_q;
  assign bus.lcd_rs   = rs_q;

  // Message buffer: writable only while idle; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[bus.msg_wr_addr] <= bus.msg_wr_data;
  end

  // Byte that follows the current one: init command table, then message buffer.
  always_comb begin
    next_byte = mem_q[msg_sel];
    if (next_idx < IDX_W'(4)) begin
      case (next_idx[1:0])
        2'd0:    next_byte = 8'h38;
        2'd1:    next_byte = 8'h0C;
        2'd2:    next_byte = 8'h06;
        default: next_byte = 8'h01;
      endcase
    end
  end

  // State, timer, byte index and LCD bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
    end
  end

  // Next-state logic; lcd_data/lcd_rs only change on entry to StSetup.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    unique case (state_q)
      StIdle, StFin: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d = StSetup;
          timer_d = SetupLoad;
          idx_d   = '0;
          data_d  = 8'h38;
          rs_d    = 1'b0;
        end
      end
      StSetup: begin
        if (timer_zero) begin
          state_d = StPulse;
          timer_d = PulseLoad;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StPulse: begin
        if (timer_zero) begin
          state_d = StGap;
          timer_d = clear_cmd ? ClearLoad : GapLoad;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StGap: begin
        if (!timer_zero) begin
          timer_d = timer_q - 1'b1;
        end else if (idx_q == LastIdx) begin
          state_d = StFin;
        end else begin
          state_d = StSetup;
          timer_d = SetupLoad;
          idx_d   = next_idx;
          data_d  = next_byte;
          rs_d    = (next_idx >= IDX_W'(4));
        end
      end
      default: state_d = StIdle;
    endcase
  end
endmodule
